// File: rtl/system_memory.sv
// Word-addressed 16-bit system memory with a processor port and a streaming
// program-loader port that holds the processor off while it fills memory.
module system_memory #(
  parameter int ADDR_BITS = 12,
  parameter int LOAD_BASE = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wd_i,
  input  logic        mem_we_i,
  output logic [15:0] mem_rd_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [15:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic [15:0] load_count_o,
  output logic        load_ovf_o,
  output logic        err_oob_o
);

  // state   | meaning
  // IDLE    | processor owns memory, loader idle
  // LOAD    | loader streams words from the pointer upward, processor held
  // RELEASE | one-cycle load_done pulse, processor still held
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(LOAD_BASE);
  localparam logic [ADDR_BITS-1:0] TOP  = '1;

  logic [15:0]          mem_q [DEPTH];
  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [15:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 err_q, err_d;

  logic                 in_range;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 xfer;
  logic                 cpu_we;

  assign in_range = (mem_addr_i[15:ADDR_BITS] == '0);
  assign word_idx = mem_addr_i[ADDR_BITS-1:0];
  assign xfer     = (state_q == ST_LOAD) && load_valid_i;
  assign cpu_we   = (state_q == ST_IDLE) && mem_we_i && in_range;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (load_start_i) state_d = ST_LOAD;
      ST_LOAD:    if (xfer && (load_last_i || ptr_q == TOP)) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_hold_o   = 1'b0;
    load_ready_o = 1'b0;
    load_done_o  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        cpu_hold_o   = 1'b1;
        load_ready_o = 1'b1;
      end
      ST_RELEASE: begin
        cpu_hold_o  = 1'b1;
        load_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Held-off processor writes are silently dropped; out-of-range reads flag in any state.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    err_d   = err_q | (!in_range && (!mem_we_i || state_q == ST_IDLE));
    if (state_q == ST_IDLE && load_start_i) begin
      ptr_d   = BASE;
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (xfer) begin
      ptr_d = ptr_q + 1'b1;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      if (ptr_q == TOP && !load_last_i) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q   <= BASE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared by reset; nothing is written during a reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (cpu_we)    mem_q[word_idx] <= mem_wd_i;
      else if (xfer) mem_q[ptr_q]    <= load_data_i;
    end
  end

  assign mem_rd_o     = in_range ? mem_q[word_idx] : 16'h0000;
  assign load_count_o = count_q;
  assign load_ovf_o   = ovf_q;
  assign err_oob_o    = err_q;

endmodule

// File: tb/tb_system_memory.sv
// Bench for system_memory: directed scenarios plus randomized traffic checked
// against a behavioural model of memory contents and load-session rules.
module tb_system_memory;

  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [15:0] addr = '0, wd = '0, rd;
  logic        we = 1'b0;
  logic        start = 1'b0, valid = 1'b0, last = 1'b0;
  logic [15:0] data = '0;
  logic        ready, hold, done, ovf, err;
  logic [15:0] count;

  system_memory #(.ADDR_BITS(12), .LOAD_BASE(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_addr_i(addr), .mem_wd_i(wd), .mem_we_i(we), .mem_rd_o(rd),
    .load_start_i(start), .load_valid_i(valid), .load_data_i(data), .load_last_i(last),
    .load_ready_o(ready), .cpu_hold_o(hold), .load_done_o(done),
    .load_count_o(count), .load_ovf_o(ovf), .err_oob_o(err)
  );

  logic        s_rst = 1'b0;
  logic [15:0] s_addr = '0, s_rd;
  logic        s_start = 1'b0, s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, s_hold, s_done, s_ovf, s_err;
  logic [15:0] s_count;

  system_memory #(.ADDR_BITS(4), .LOAD_BASE(14)) dut_s (
    .clk_i(clk), .rst_i(s_rst),
    .mem_addr_i(s_addr), .mem_wd_i(16'h0000), .mem_we_i(1'b0), .mem_rd_o(s_rd),
    .load_start_i(s_start), .load_valid_i(s_valid), .load_data_i(s_data), .load_last_i(1'b0),
    .load_ready_o(s_ready), .cpu_hold_o(s_hold), .load_done_o(s_done),
    .load_count_o(s_count), .load_ovf_o(s_ovf), .err_oob_o(s_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory image, which words are known, and session status.
  logic [15:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  bit          m_loading, m_release;
  int          m_ptr, m_count;
  bit          m_ovf, m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Compare outputs for the current inputs, then clock once and advance the model.
  task automatic step();
    bit inr;
    #1;
    inr = (addr < DEPTH);
    check_val("cpu_hold", hold, m_loading || m_release);
    check_val("load_ready", ready, m_loading);
    check_val("load_done", done, m_release);
    check_val("load_count", count, m_count);
    check_val("load_ovf", ovf, m_ovf);
    check_val("err_oob", err, m_err);
    if (!inr) check_val("rd_oob", rd, 16'h0000);
    else if (known[addr]) check_val("mem_rd", rd, ref_mem[addr]);
    @(posedge clk);
    if (!rst) begin
      m_loading = 0; m_release = 0; m_ptr = 0; m_count = 0; m_ovf = 0; m_err = 0;
    end else if (m_release) begin
      m_release = 0;
      if (!inr && !we) m_err = 1;
    end else if (m_loading) begin
      if (!inr && !we) m_err = 1;
      if (valid) begin
        ref_mem[m_ptr] = data;
        known[m_ptr] = 1;
        if (m_count < 65535) m_count++;
        if (last || m_ptr == DEPTH - 1) begin
          m_loading = 0;
          m_release = 1;
          if (!last) m_ovf = 1;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else begin
      if (!inr) m_err = 1;
      else if (we) begin
        ref_mem[addr] = wd;
        known[addr] = 1;
      end
      if (start) begin
        m_loading = 1; m_ptr = 0; m_count = 0; m_ovf = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; start = 0; valid = 0; last = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    m_loading = 0; m_release = 0; m_ptr = 0; m_count = 0; m_ovf = 0; m_err = 0;

    // Reset both instances together.
    rst = 0; s_rst = 0;
    step();
    rst = 1; s_rst = 1;

    // Small instance: load from 14 without load_last wraps at address 15.
    s_start = 1;
    step();
    s_start = 0; s_valid = 1; s_data = 16'hC000;
    #1 check_val("s_ready_load", s_ready, 1);
    step();
    s_data = 16'hC001;
    step();
    s_data = 16'hC002;
    #1 check_val("s_ready_release", s_ready, 0);
    check_val("s_done", s_done, 1);
    check_val("s_hold_release", s_hold, 1);
    step();
    s_valid = 0;
    #1 check_val("s_hold_idle", s_hold, 0);
    check_val("s_count", s_count, 2);
    check_val("s_ovf", s_ovf, 1);
    s_addr = 16'd14;
    #1 check_val("s_mem14", s_rd, 16'hC000);
    s_addr = 16'd15;
    #1 check_val("s_mem15", s_rd, 16'hC001);
    check_val("s_err", s_err, 0);

    // Processor write then zero-wait read.
    we = 1; addr = 16'h0005; wd = 16'hBEEF;
    step();
    we = 0;
    #1 check_val("rd_beef", rd, 16'hBEEF);
    check_val("err_clean", err, 0);
    step();

    // Out-of-range write is dropped and flags err_oob.
    we = 1; addr = 16'h0000; wd = 16'h5A5A;
    step();
    addr = 16'h1000; wd = 16'h1234;
    step();
    we = 0;
    #1 check_val("rd_oob_1000", rd, 16'h0000);
    check_val("err_sticky", err, 1);
    addr = 16'h0000;
    #1 check_val("mem0_kept", rd, 16'h5A5A);
    step();

    // Four-word load with a valid gap; processor write during the gap is ignored.
    start = 1;
    step();
    start = 0; valid = 1; data = 16'hA000;
    step();
    data = 16'hA001;
    step();
    valid = 0; we = 1; addr = 16'h0002; wd = 16'hFFFF;
    step();
    we = 0; addr = 16'h0000; valid = 1; data = 16'hA002;
    step();
    data = 16'hA003; last = 1;
    step();
    valid = 0; last = 0;
    #1 check_val("done_pulse", done, 1);
    check_val("hold_release", hold, 1);
    step();
    #1 check_val("hold_after", hold, 0);
    check_val("done_after", done, 0);
    check_val("count4", count, 4);
    check_val("ovf0", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      addr = 16'(i);
      #1 check_val("load_word", rd, 32'hA000 + 32'(i));
    end
    step();

    // Reset in the middle of a load.
    start = 1;
    step();
    start = 0; valid = 1; data = 16'hB000;
    step();
    data = 16'hB001;
    step();
    valid = 0; rst = 0;
    step();
    rst = 1;
    #1 check_val("hold_rst", hold, 0);
    check_val("count_rst", count, 0);
    addr = 16'h0001;
    #1 check_val("mem1_kept", rd, 16'hB001);
    start = 1;
    step();
    start = 0;
    #1 check_val("ready_restart", ready, 1);
    valid = 1; last = 1; data = 16'hB100;
    step();
    idle_inputs();
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 7) == 0);
      valid = ($urandom_range(0, 3) != 0);
      last  = ($urandom_range(0, 5) == 0);
      data  = 16'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      wd    = 16'($urandom);
      addr  = ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
